// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, default
// widths and the legal wait-latency window.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_t;

    localparam int DM_ADDR_W  = 7;
    localparam int DM_DATA_W  = 32;

    localparam int DM_LAT_MIN = 1;
    localparam int DM_LAT_MAX = 15;
    // Wide enough to hold DM_LAT_MAX-1
    localparam int DM_CNT_W   = 4;

endpackage

// File: rtl/dm_responder_if.sv
// Request/response channel between the memory stage and the data-memory
// responder; master = pipeline side, slave = responder.
interface dm_responder_if
    import dm_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;

    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_write, rsp_rdata, busy
    );
endinterface

// File: rtl/dm_array.sv
// Single-ported word storage: synchronous write, asynchronous read, no reset
// so contents survive a responder reset.
module dm_array
    import dm_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, then
// performs the single array access and holds the response until taken.
//
//   state | meaning
//   IDLE  | ready for a command, req_ready high
//   WAIT  | command latched, counting down the programmed latency
//   RESP  | response valid, held until rsp_ready
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W  = DM_ADDR_W,
    parameter int DATA_W  = DM_DATA_W,
    parameter int LATENCY = 2
) (
    input logic           CLK,
    input logic           RST_n,
    dm_responder_if.slave bus
);

    if (LATENCY < DM_LAT_MIN || LATENCY > DM_LAT_MAX) begin : g_bad_latency
        $error("dm_responder: LATENCY must lie in 1..15");
    end

    localparam logic [DM_CNT_W-1:0] CNT_LOAD = DM_CNT_W'(LATENCY - 1);

    dm_state_t           state_q;
    dm_state_t           state_d;
    logic                accept;
    logic                access;
    logic                done;

    logic [DM_CNT_W-1:0] cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                write_q;

    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_write_q;

    logic [DATA_W-1:0]   array_rdata;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        access  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q   <= CNT_LOAD;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                write_q <= bus.req_write;
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end

            // A store echoes its own data rather than the pre-write array word
            if (access) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= write_q ? wdata_q : array_rdata;
                rsp_write_q <= write_q;
            end else if (done) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    dm_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .CLK   (CLK),
        .we    (access & write_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (array_rdata)
    );

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_write = rsp_write_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances (LATENCY 2, 1, 4) driven from one
// sequence, responses checked against a per-instance expectation queue.
module tb_dm_responder;
    import dm_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n     [3];
    logic        req_valid [3];
    logic        req_write [3];
    logic [6:0]  req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_ready [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic        rsp_write [3];
    logic        busy      [3];
    logic [31:0] rsp_rdata [3];

    exp_t        sb_q  [3][$];
    logic [31:0] model [3][128];
    int          acc_cyc [3];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

        dm_responder_if #(.ADDR_W(7), .DATA_W(32)) bus ();

        assign bus.req_valid = req_valid[g];
        assign bus.req_write = req_write[g];
        assign bus.req_addr  = req_addr[g];
        assign bus.req_wdata = req_wdata[g];
        assign bus.rsp_ready = rsp_ready[g];
        assign req_ready[g]  = bus.req_ready;
        assign rsp_valid[g]  = bus.rsp_valid;
        assign rsp_write[g]  = bus.rsp_write;
        assign rsp_rdata[g]  = bus.rsp_rdata;
        assign busy[g]       = bus.busy;

        dm_responder #(.ADDR_W(7), .DATA_W(32), .LATENCY(LAT)) u_dut (
            .CLK   (clk),
            .RST_n (rst_n[g]),
            .bus   (bus)
        );

        logic        prev_v   = 1'b0;
        logic        prev_rdy = 1'b0;
        logic        prev_w   = 1'b0;
        logic [31:0] prev_d   = '0;

        always @(negedge clk) begin : mon
            exp_t e;
            if (rst_n[g] !== 1'b1) begin
                prev_v = 1'b0;
            end else begin
                if (prev_v && prev_rdy) begin
                    check_eq("hs_clear", 32'(rsp_valid[g]), 32'd0);
                end else if (prev_v) begin
                    check_eq("hold_valid", 32'(rsp_valid[g]), 32'd1);
                    check_eq("hold_data", rsp_rdata[g], prev_d);
                    check_eq("hold_write", 32'(rsp_write[g]), 32'(prev_w));
                end
                if (rsp_valid[g] && !prev_v) begin
                    check_eq("latency", cyc - acc_cyc[g], LAT);
                    check_eq("busy_resp", 32'(busy[g]), 32'd1);
                end
                if (rsp_valid[g] && rsp_ready[g]) begin
                    if (sb_q[g].size() == 0) begin
                        check_eq("sb_empty", 32'd1, 32'd0);
                    end else begin
                        e = sb_q[g].pop_front();
                        check_eq("rdata", rsp_rdata[g], e.data);
                        check_eq("rwrite", 32'(rsp_write[g]), 32'(e.wr));
                    end
                end
                prev_v   = rsp_valid[g];
                prev_rdy = rsp_ready[g];
                prev_w   = rsp_write[g];
                prev_d   = rsp_rdata[g];
            end
        end
    end

    // Inputs change 1ns after the rising edge, outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic wr, input logic [6:0] a, input logic [31:0] d);
        exp_t e;
        int   n;
        n            = 0;
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i]  = a;
        req_wdata[i] = d;
        e.wr         = wr;
        e.data       = wr ? d : model[i][a];
        if (wr) model[i][a] = d;
        sb_q[i].push_back(e);
        while (!req_ready[i] && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) check_eq("accept_timeout", 32'd0, 32'd1);
        acc_cyc[i] = cyc + 1;
        tick();
        req_valid[i] = 1'b0;
        check_eq("rdy_drop", 32'(req_ready[i]), 32'd0);
    endtask

    task automatic wait_rsp_valid(input int i);
        int n;
        n = 0;
        while (!rsp_valid[i] && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) check_eq("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while ((sb_q[i].size() != 0 || !req_ready[i]) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check_eq("drain_timeout", 32'(sb_q[i].size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i]     = 1'b0;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            rsp_ready[i] = 1'b1;
            acc_cyc[i]   = 0;
        end

        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_req_ready", 32'(req_ready[i]), 32'd1);
            check_eq("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            check_eq("rst_rsp_rdata", rsp_rdata[i], 32'd0);
            check_eq("rst_rsp_write", 32'(rsp_write[i]), 32'd0);
            check_eq("rst_busy", 32'(busy[i]), 32'd0);
            rst_n[i] = 1'b1;
        end
        tick();

        // LATENCY 2: store then load the same word
        issue(0, 1'b1, 7'h05, 32'hDEADBEEF);
        issue(0, 1'b0, 7'h05, 32'h0);
        wait_idle(0);

        // Backpressure: response held 5 cycles while a second request waits
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 7'h05, 32'h0);
        wait_rsp_valid(0);
        fork
            issue(0, 1'b1, 7'h06, 32'h0BADF00D);
            begin
                repeat (5) begin
                    check_eq("bp_valid", 32'(rsp_valid[0]), 32'd1);
                    check_eq("bp_ready", 32'(req_ready[0]), 32'd0);
                    check_eq("bp_data", rsp_rdata[0], 32'hDEADBEEF);
                    tick();
                end
                rsp_ready[0] = 1'b1;
                tick();
                check_eq("bp_idle_ready", 32'(req_ready[0]), 32'd1);
                check_eq("bp_idle_busy", 32'(busy[0]), 32'd0);
                tick();
                check_eq("bp_held_accept", 32'(busy[0]), 32'd1);
            end
        join
        wait_idle(0);

        // LATENCY 1: back-to-back at the top and bottom of the address space
        issue(1, 1'b1, 7'h7F, 32'h00000001);
        issue(1, 1'b0, 7'h7F, 32'h0);
        issue(1, 1'b1, 7'h00, 32'hFFFFFFFF);
        issue(1, 1'b0, 7'h00, 32'h0);
        issue(1, 1'b0, 7'h7F, 32'h0);
        wait_idle(1);

        // LATENCY 4: a store interrupted by reset in WAIT never reaches the array
        issue(2, 1'b1, 7'h10, 32'h00000000);
        wait_idle(2);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 7'h10;
        req_wdata[2] = 32'hA5A5A5A5;
        tick();
        req_valid[2] = 1'b0;
        check_eq("mid_busy", 32'(busy[2]), 32'd1);
        tick();
        tick();
        #2 rst_n[2] = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(rsp_valid[2]), 32'd0);
        check_eq("mid_rst_busy", 32'(busy[2]), 32'd0);
        check_eq("mid_rst_ready", 32'(req_ready[2]), 32'd1);
        tick();
        rst_n[2] = 1'b1;
        tick();
        issue(2, 1'b0, 7'h10, 32'h0);
        wait_idle(2);

        // Command inputs changed during WAIT must not affect the transaction
        issue(2, 1'b1, 7'h03, 32'h33333333);
        issue(2, 1'b1, 7'h04, 32'h44444444);
        wait_idle(2);
        issue(2, 1'b0, 7'h03, 32'h0);
        req_addr[2]  = 7'h04;
        req_write[2] = 1'b1;
        req_wdata[2] = 32'hCAFEF00D;
        wait_idle(2);
        issue(2, 1'b0, 7'h04, 32'h0);
        wait_idle(2);

        // Reset while a store response is pending: response lost, array keeps the word
        rsp_ready[2] = 1'b0;
        issue(2, 1'b1, 7'h20, 32'h12345678);
        wait_rsp_valid(2);
        tick();
        #2 rst_n[2] = 1'b0;
        #1;
        check_eq("resp_rst_valid", 32'(rsp_valid[2]), 32'd0);
        check_eq("resp_rst_rdata", rsp_rdata[2], 32'd0);
        check_eq("resp_rst_write", 32'(rsp_write[2]), 32'd0);
        check_eq("resp_rst_busy", 32'(busy[2]), 32'd0);
        sb_q[2].delete();
        tick();
        rst_n[2]     = 1'b1;
        rsp_ready[2] = 1'b1;
        tick();
        issue(2, 1'b0, 7'h20, 32'h0);
        wait_idle(2);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
